// File: rtl/mem_lsu.sv
// Load/store unit: one outstanding access to a variable-latency memory over a
// valid/ready request channel and a valid response channel.
module mem_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_flush,
  input  logic              ex_mb__valid,
  input  logic              ex_mb__dmem_read,
  input  logic              ex_mb__dmem_write,
  input  logic [1:0]        ex_mb__dmem_width,
  input  logic              ex_mb__dmem_zero_ext,
  input  logic [ADDR_W-1:0] ex_mb__addr,
  input  logic [XLEN-1:0]   ex_mb__wdata,
  output logic              mb_ex__stall,
  output logic              mb_ex__load_misalign,
  output logic              mb_ex__store_misalign,
  output logic [ADDR_W-1:0] mb_ex__trap_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [XLEN/8-1:0] mem_req_be,
  output logic [XLEN-1:0]   mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  output logic              mb_wb__valid,
  output logic [XLEN-1:0]   mb_wb__rdata
);

  localparam int LANES = XLEN / 8;
  localparam int LB    = $clog2(LANES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  function automatic logic [LANES-1:0] byte_en(input logic [1:0] w, input logic [LB-1:0] l);
    case (w)
      2'd0:    byte_en = LANES'(1) << l;
      2'd1:    byte_en = LANES'(3) << l;
      2'd2:    byte_en = LANES'(15) << l;
      default: byte_en = '1;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] raw, input logic [LB-1:0] l,
                                               input logic [1:0] w, input logic zx);
    logic [XLEN-1:0] s;
    s = raw >> {l, 3'b000};
    case (w)
      2'd0:    load_ext = zx ? XLEN'(s[7:0])  : XLEN'($signed(s[7:0]));
      2'd1:    load_ext = zx ? XLEN'(s[15:0]) : XLEN'($signed(s[15:0]));
      2'd2:    load_ext = zx ? XLEN'(s[31:0]) : XLEN'($signed(s[31:0]));
      default: load_ext = s;
    endcase
  endfunction

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LANES-1:0]  be_q, be_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [LB-1:0]     lane_q, lane_d;
  logic [1:0]        width_q, width_d;
  logic              zext_q, zext_d;
  logic              wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]   wb_rdata_q, wb_rdata_d;

  logic          misalign, op_present, accept, trap, handshake;
  logic [LB-1:0] lane_in;

  assign lane_in = ex_mb__addr[LB-1:0];

  always_comb begin
    case (ex_mb__dmem_width)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = ex_mb__addr[0];
      2'd2:    misalign = (ex_mb__addr[1:0] != 2'b00);
      default: misalign = (XLEN == 32) || (ex_mb__addr[2:0] != 3'b000);
    endcase
  end

  assign op_present = (state_q == S_IDLE) && ex_mb__valid && !pipe_flush
                      && (ex_mb__dmem_read || ex_mb__dmem_write);
  assign accept     = op_present && !misalign;
  assign trap       = op_present && misalign;
  assign handshake  = (state_q == S_REQ) && mem_req_ready;

  assign mb_ex__load_misalign  = trap && ex_mb__dmem_read;
  assign mb_ex__store_misalign = trap && !ex_mb__dmem_read;
  assign mb_ex__trap_addr      = ex_mb__addr;
  assign mb_ex__stall          = accept || (state_q != S_IDLE);

  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_be    = be_q;
  assign mem_req_wdata = wdata_q;
  assign mb_wb__valid  = wb_valid_q;
  assign mb_wb__rdata  = wb_rdata_q;

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    lane_d     = lane_q;
    width_d    = width_q;
    zext_d     = zext_q;
    wb_valid_d = 1'b0;
    wb_rdata_d = wb_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_REQ;
          we_d    = !ex_mb__dmem_read;
          addr_d  = {ex_mb__addr[ADDR_W-1:LB], {LB{1'b0}}};
          be_d    = byte_en(ex_mb__dmem_width, lane_in);
          wdata_d = ex_mb__wdata << {lane_in, 3'b000};
          lane_d  = lane_in;
          width_d = ex_mb__dmem_width;
          zext_d  = ex_mb__dmem_zero_ext;
        end
      end
      S_REQ: begin
        // A flush on the handshake cycle cannot recall the issued access.
        if (handshake) begin
          if (we_q) begin
            state_d    = S_IDLE;
            wb_valid_d = !pipe_flush;
          end else begin
            state_d = pipe_flush ? S_DRAIN : S_WAIT;
          end
        end else if (pipe_flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = S_IDLE;
          if (!pipe_flush) begin
            wb_valid_d = 1'b1;
            wb_rdata_d = load_ext(mem_rsp_rdata, lane_q, width_q, zext_q);
          end
        end else if (pipe_flush) begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        if (mem_rsp_valid) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      lane_q     <= '0;
      width_q    <= 2'd0;
      zext_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      lane_q     <= lane_d;
      width_q    <= width_d;
      zext_q     <= zext_d;
      wb_valid_q <= wb_valid_d;
      wb_rdata_q <= wb_rdata_d;
    end
  end

endmodule
